// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 16-bit CPU pipeline.
// Holds the word/address types and the IF/ID pipeline record.
package cpu_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  localparam word_t DEFAULT_NOP_WORD = 16'h0800;
  localparam addr_t DEFAULT_RESET_PC = 16'h0000;

  typedef struct packed {
    word_t ins;
    addr_t pc;
    addr_t pc_plus1;
    logic  valid;
  } if_id_t;

  // Address arithmetic wraps modulo 2^16.
  function automatic addr_t addr_inc(input addr_t a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// load captures a new fetch record, bubble inserts a NOP and keeps the address fields, otherwise it holds.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter word_t NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{ins: NOP_WORD, pc: '0, pc_plus1: '0, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.ins   <= NOP_WORD;
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, slow-SRAM wait counter, Ram2 arbitration and redirect handling.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (redirect keeps the in-flight fetch as a delay slot).
module if_stage
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC    = DEFAULT_RESET_PC,
  parameter int    WAIT_CYCLES = 0,
  parameter word_t NOP_WORD    = DEFAULT_NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  output addr_t pc_out,
  input  word_t ins_in,
  input  logic  ram2_busy,
  input  logic  stall,
  input  logic  redirect,
  input  addr_t redirect_pc,
  output word_t id_ins,
  output addr_t id_pc,
  output addr_t id_pc_plus1,
  output logic  id_valid
);

  localparam logic [2:0] WAIT_MAX = 3'((WAIT_CYCLES > 7) ? 7 : WAIT_CYCLES);

  addr_t      pc, pc_next;
  logic [2:0] wait_cnt, wait_next, wait_inc;
  logic       fc;
  logic       ifid_load, ifid_bubble;
  if_id_t     ifid_d, ifid_q;

`ifdef BRANCH_DELAY_SLOT_EN
  logic  pending, pending_next;
  addr_t target, target_next;
`endif

  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 3'd1;
  assign fc       = (wait_cnt == WAIT_MAX) && !ram2_busy;
  assign ifid_d   = '{ins: ins_in, pc: pc, pc_plus1: addr_inc(pc), valid: 1'b1};

  // NOTE: every signal driven here gets a default first, so no path through
  // the priority chain can leave one unassigned and infer a latch.
  always_comb begin
    pc_next      = pc;
    wait_next    = ram2_busy ? 3'd0 : wait_inc;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pending_next = pending;
    target_next  = target;
`endif

    if (stall) begin
      // Everything holds; a redirect seen now is re-asserted by ID after release.
    end else if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (fc) begin
        ifid_load    = 1'b1;
        pc_next      = redirect_pc;
        pending_next = 1'b0;
        wait_next    = 3'd0;
      end else begin
        // Delay slot still in flight: remember the target, finish the slot first.
        ifid_bubble  = 1'b1;
        pending_next = 1'b1;
        target_next  = redirect_pc;
      end
`else
      pc_next     = redirect_pc;
      ifid_bubble = 1'b1;
      wait_next   = 3'd0;
`endif
    end else if (fc) begin
      ifid_load = 1'b1;
      wait_next = 3'd0;
`ifdef BRANCH_DELAY_SLOT_EN
      pc_next      = pending ? target : addr_inc(pc);
      pending_next = 1'b0;
`else
      pc_next = addr_inc(pc);
`endif
    end else begin
      ifid_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      wait_cnt <= 3'd0;
    end else begin
      pc       <= pc_next;
      wait_cnt <= wait_next;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      target  <= '0;
    end else begin
      pending <= pending_next;
      target  <= target_next;
    end
  end
`endif

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .bubble(ifid_bubble),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc_out      = pc;
  assign id_ins      = ifid_q.ins;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus1 = ifid_q.pc_plus1;
  assign id_valid    = ifid_q.valid;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit CPU: owns the program counter, drives the fetch address into the instruction-memory block (which returns the Ram2 word combinationally), and registers the fetched word into the IF/ID pipeline register for decode. Handles slow-SRAM wait states, Ram2 conflicts with the data stage, pipeline stalls and branch/jump redirects. It sits directly upstream of instruction memory (address out) and wraps its output (instruction in).

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- WAIT_CYCLES, 0, extra cycles the fetch address must be held stable before ins_in is sampled (0..7)
- NOP_WORD, 16'h0800, bubble instruction inserted into IF/ID

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_out  out  16  fetch address to instruction memory (registered PC)
- ins_in  in  16  instruction word from instruction memory for pc_out
- ram2_busy  in  1  data stage owns Ram2 this cycle; fetch cannot complete
- stall  in  1  hazard unit hold; PC and IF/ID hold
- redirect  in  1  branch/jump taken, resolved in ID
- redirect_pc  in  16  target address
- id_ins  out  16  IF/ID instruction
- id_pc  out  16  address of id_ins
- id_pc_plus1  out  16  id_pc + 1
- id_valid  out  1  id_ins is a real instruction (0 = bubble)

## Operation
- Reset (rst=0, async): pc_out=RESET_PC, id_ins=NOP_WORD, id_pc=0, id_pc_plus1=0, id_valid=0, wait_cnt=0, pending=0.
- wait_cnt counts cycles the current address has been presented with Ram2 free; width 3 bits, saturates at WAIT_CYCLES.
- Fetch-complete fc = (wait_cnt == WAIT_CYCLES) && !ram2_busy.
- Edge priority (first match wins):
  - stall=1: PC, IF/ID, pending hold; redirect ignored (ID re-asserts after release); wait_cnt <= ram2_busy ? 0 : sat_inc.
  - redirect=1 (macro absent): pc <= redirect_pc; IF/ID <= bubble; wait_cnt <= 0.
  - fc=1: IF/ID <= {ins_in, pc, pc+1, valid=1}; pc <= pending ? target : pc+1; pending <= 0; wait_cnt <= 0.
  - otherwise: IF/ID <= bubble (NOP_WORD, valid=0, id_pc/id_pc_plus1 hold); pc holds; wait_cnt <= ram2_busy ? 0 : sat_inc.
- Bubble = id_ins NOP_WORD, id_valid 0.
- PC arithmetic: 16-bit, modulo 2^16; 16'hFFFF + 1 = 16'h0000; id_pc_plus1 wraps likewise.
- ram2_busy resets wait_cnt: Ram2 address was driven by data stage, so fetch restarts its wait.

## Timing
- pc_out is registered; ins_in is sampled on the same edge it is valid (combinational memory path).
- WAIT_CYCLES=0, no hazards: one instruction per cycle; id_ins at edge n+1 is the word at pc_out of cycle n.
- Per-fetch latency = WAIT_CYCLES+1 cycles, plus one cycle per ram2_busy cycle, plus restart of the wait.
- Redirect: target appears on pc_out the cycle after the redirect edge; its instruction reaches IF/ID WAIT_CYCLES+1 cycles later.
- Reset released mid-fetch: first fetch is RESET_PC with wait_cnt=0.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: instruction in IF when redirect asserts is the delay slot and is not squashed. redirect with fc=1: IF/ID captures it, pc <= redirect_pc. redirect with fc=0: pending <= 1, target <= redirect_pc, bubble; delay slot completes later via fc rule. Redirect while pending overwrites target.
- Undefined: redirect squashes IF (bubble), immediate PC load; pending/target registers absent.

## Structure
- Shared cpu_pkg: word_t/addr_t (16-bit) typedefs, NOP_WORD constant, RESET_PC default.
- One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls and async active-low reset); PC, wait counter and pending logic in if_stage.

## Test plan
- Reset, WAIT_CYCLES=0, memory word = address: id_ins 0,1,2,3 on consecutive edges, id_valid=1, id_pc_plus1 = id_pc+1.
- WAIT_CYCLES=2: pc_out holds each address 3 cycles; two bubbles (id_ins=16'h0800, id_valid=0) between valid words.
- ram2_busy pulsed for 1 cycle at wait_cnt=1 (WAIT_CYCLES=2): wait restarts, fetch completes 3 cycles after busy drops.
- stall=1 for 4 cycles with redirect=1 during stall: pc_out and IF/ID frozen, redirect ignored.
- Macro absent, redirect to 16'h0040 at pc=5: next id_valid=0, pc_out=16'h0040, then id_ins=mem[0x40]; macro defined: id_ins=mem[5] then mem[0x40].
- pc=16'hFFFF, fetch: id_pc=16'hFFFF, id_pc_plus1=16'h0000, pc_out=16'h0000.
